// File: rtl/npn_pkg.sv
// Shared types and constants for the NPN truth-table capture block.
package npn_pkg;

    localparam int TT_W      = 16;
    localparam int N_MINTERM = 16;
    localparam int IDX_W     = 4;
    localparam int ONES_W    = 5;

    // Truth table the capture block compares against unless overridden.
    localparam logic [TT_W-1:0] EXP_TT_DEFAULT = 16'hE766;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } npn_state_e;

    // Running population count: add one captured bit to the total.
    function automatic logic [ONES_W-1:0] ones_add(input logic [ONES_W-1:0] cnt,
                                                   input logic            bit_in);
        return cnt + {{(ONES_W-1){1'b0}}, bit_in};
    endfunction

endpackage

// File: rtl/npn_lat_pipe.sv
// Valid/index delay line: tells the capture logic which minterm the
// returning y0 belongs to, LAT cycles after that minterm was driven.
module npn_lat_pipe
    import npn_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    generate
        if (LAT == 0) begin : g_pass
            // Zero latency: the minterm driven this cycle is captured this cycle.
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
        end else begin : g_pipe
            logic [LAT-1:0]            vld_q;
            logic [LAT-1:0]            vld_d;
            logic [LAT-1:0][IDX_W-1:0] idx_q;
            logic [LAT-1:0][IDX_W-1:0] idx_d;

            // Shift the valid/index pair one stage per cycle.
            always_comb begin
                vld_d    = vld_q;
                idx_d    = idx_q;
                vld_d[0] = in_valid;
                idx_d[0] = in_idx;
                for (int i = 1; i < LAT; i++) begin
                    vld_d[i] = vld_q[i-1];
                    idx_d[i] = idx_q[i-1];
                end
            end

            // Delay-line registers; reset empties the line.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    idx_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    idx_q <= idx_d;
                end
            end

            assign out_valid = vld_q[LAT-1];
            assign out_idx   = idx_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/npn_tt_capture.sv
// Sweeps all 16 minterms into a downstream 4-input function and records
// its answers as a truth table, with popcount and expected-value match.
module npn_tt_capture
    import npn_pkg::*;
#(
    parameter int              LAT    = 1,
    parameter logic [TT_W-1:0] EXP_TT = EXP_TT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              x0,
    output logic              x1,
    output logic              x2,
    output logic              x3,
    input  logic              y0,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic [ONES_W-1:0] ones,
    output logic              match
);

    npn_state_e        state_q, state_d;
    logic [IDX_W-1:0]  x_q, x_d;
    logic [1:0]        drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              match_q, match_d;

    logic              cap_valid_s;
    logic [IDX_W-1:0]  cap_idx_s;
    logic              pipe_in_valid_s;

    // The driven minterm enters the delay line only while sweeping.
    assign pipe_in_valid_s = (state_q == ST_DRIVE);

    npn_lat_pipe #(
        .LAT(LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (pipe_in_valid_s),
        .in_idx   (x_q),
        .out_valid(cap_valid_s),
        .out_idx  (cap_idx_s)
    );

    // Next-state, minterm sequencing and truth-table capture.
    always_comb begin
        state_d = state_q;
        x_d     = 4'd0;
        drain_d = drain_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        match_d = match_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    tt_d    = '0;
                    ones_d  = '0;
                    match_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (x_q == 4'd15) begin
                    drain_d = 2'd0;
                    if (LAT == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    x_d = x_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'(LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The delay line only carries minterms from the current sweep,
        // so a capture never coincides with the clear on leaving IDLE.
        if (cap_valid_s) begin
            tt_d[cap_idx_s] = y0;
            ones_d          = ones_add(ones_q, y0);
            match_d         = (tt_d == EXP_TT);
        end else begin
            ones_d = ones_d;
        end

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= 4'd0;
            drain_q <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            match_q <= match_d;
        end
    end

    assign x0    = x_q[0];
    assign x1    = x_q[1];
    assign x2    = x_q[2];
    assign x3    = x_q[3];
    assign busy  = busy_q;
    assign done  = done_q;
    assign tt    = tt_q;
    assign ones  = ones_q;
    assign match = match_q;

endmodule

// File: tb/tb_npn_tt_capture.sv
// Bench for npn_tt_capture: three instances (LAT 0, 1, 3) with behavioural
// downstream functions; expected results queued at start, checked at done.
module tb_npn_tt_capture;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        match;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic      start_s [3];
    logic      rst_s   [3];
    logic      y_s     [3];
    int        mode_s  [3];

    wire [3:0]  x_w     [3];
    wire        busy_w  [3];
    wire        done_w  [3];
    wire [15:0] tt_w    [3];
    wire [4:0]  ones_w  [3];
    wire        match_w [3];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Downstream functions: 0 = expected table, 1 = stuck 0, 2 = stuck 1, 3 = x0^x1.
    function automatic logic fn(input int mode, input logic [3:0] k);
        logic [15:0] t;
        t = 16'hE766;
        case (mode)
            0:       return t[k];
            1:       return 1'b0;
            2:       return 1'b1;
            default: return k[0] ^ k[1];
        endcase
    endfunction

    function automatic exp_t make_exp(input int mode);
        exp_t e;
        e.tt   = 16'h0000;
        e.ones = 5'd0;
        for (int k = 0; k < 16; k++) begin
            e.tt[k] = fn(mode, 4'(k));
            e.ones  = e.ones + {4'd0, e.tt[k]};
        end
        e.match = (e.tt == 16'hE766);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // LAT=0 downstream: purely combinational.
    assign y_s[0] = fn(mode_s[0], x_w[0]);

    // LAT=1 downstream: function registered once.
    logic y1_r = 1'b0;
    always @(posedge clk) y1_r <= fn(mode_s[1], x_w[1]);
    assign y_s[1] = y1_r;

    // LAT=3 downstream: function delayed three cycles.
    logic [2:0] y3_r = 3'b000;
    always @(posedge clk) y3_r <= {y3_r[1:0], fn(mode_s[2], x_w[2])};
    assign y_s[2] = y3_r[2];

    npn_tt_capture #(.LAT(0)) dut0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
        .x0(x_w[0][0]), .x1(x_w[0][1]), .x2(x_w[0][2]), .x3(x_w[0][3]),
        .y0(y_s[0]), .busy(busy_w[0]), .done(done_w[0]),
        .tt(tt_w[0]), .ones(ones_w[0]), .match(match_w[0])
    );

    npn_tt_capture #(.LAT(1)) dut1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
        .x0(x_w[1][0]), .x1(x_w[1][1]), .x2(x_w[1][2]), .x3(x_w[1][3]),
        .y0(y_s[1]), .busy(busy_w[1]), .done(done_w[1]),
        .tt(tt_w[1]), .ones(ones_w[1]), .match(match_w[1])
    );

    npn_tt_capture #(.LAT(3)) dut3 (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]),
        .x0(x_w[2][0]), .x1(x_w[2][1]), .x2(x_w[2][2]), .x3(x_w[2][3]),
        .y0(y_s[2]), .busy(busy_w[2]), .done(done_w[2]),
        .tt(tt_w[2]), .ones(ones_w[2]), .match(match_w[2])
    );

    task automatic check_zero(input int d, input string tag);
        check_eq({tag, "_tt"},    32'(tt_w[d]),    32'd0);
        check_eq({tag, "_ones"},  32'(ones_w[d]),  32'd0);
        check_eq({tag, "_match"}, 32'(match_w[d]), 32'd0);
        check_eq({tag, "_busy"},  32'(busy_w[d]),  32'd0);
        check_eq({tag, "_done"},  32'(done_w[d]),  32'd0);
        check_eq({tag, "_x"},     32'(x_w[d]),     32'd0);
    endtask

    // One sweep on instance d; cycle n counts negedges after the start edge.
    task automatic run_sweep(input int d, input int mode, input int lat, input string tag);
        exp_t e;
        int   busy_n, x_err, done_n, done_at;
        mode_s[d] = mode;
        sb.push_back(make_exp(mode));
        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk);
        #1 start_s[d] = 1'b0;
        busy_n = 0; x_err = 0; done_n = 0; done_at = -1;
        e = '{16'h0000, 5'd0, 1'b0};
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy_w[d]) busy_n++;
            if (n < 16) begin
                if (x_w[d] != 4'(n)) x_err++;
            end else begin
                if (x_w[d] != 4'd0) x_err++;
            end
            if (done_w[d]) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = n;
                    e = sb.pop_front();
                    check_eq({tag, "_tt"},    32'(tt_w[d]),    32'(e.tt));
                    check_eq({tag, "_ones"},  32'(ones_w[d]),  32'(e.ones));
                    check_eq({tag, "_match"}, 32'(match_w[d]), 32'(e.match));
                end
            end
        end
        if (done_at < 0) begin
            check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
            e = sb.pop_front();
        end else begin
            check_eq({tag, "_latency"}, 32'(done_at + 1), 32'(17 + lat));
        end
        check_eq({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(16 + lat));
        check_eq({tag, "_x_seq_errs"},  32'(x_err),  32'd0);
        check_eq({tag, "_hold_tt"},     32'(tt_w[d]),   32'(e.tt));
        check_eq({tag, "_hold_ones"},   32'(ones_w[d]), 32'(e.ones));
    endtask

    initial begin
        int   done_n, x_err, seen;
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            rst_s[d]   = 1'b1;
            mode_s[d]  = 0;
        end
        repeat (3) @(negedge clk);
        check_zero(1, "reset");
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
        done_n = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_w[1]) done_n++;
        end
        check_eq("reset_no_done", 32'(done_n), 32'd0);

        run_sweep(1, 0, 1, "lat1_exp");
        run_sweep(1, 1, 1, "lat1_stuck0");
        run_sweep(0, 3, 0, "lat0_xor");
        run_sweep(2, 2, 3, "lat3_ones");
        run_sweep(2, 0, 3, "lat3_exp");

        // Reset in the middle of a sweep, at minterm 7.
        mode_s[1] = 0;
        @(negedge clk);
        start_s[1] = 1'b1;
        @(posedge clk);
        #1 start_s[1] = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(negedge clk);
            if (x_w[1] == 4'd7) seen = 1;
        end
        check_eq("midrst_reached_k7", 32'(seen), 32'd1);
        #2 rst_s[1] = 1'b1;
        #1 check_zero(1, "midrst");
        @(negedge clk);
        rst_s[1] = 1'b0;
        done_n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_w[1]) done_n++;
        end
        check_eq("midrst_no_done", 32'(done_n), 32'd0);
        run_sweep(1, 0, 1, "after_rst");

        // Start held high: back-to-back sweeps, 19-cycle period at LAT=1.
        for (int j = 0; j < 3; j++) sb.push_back(make_exp(0));
        @(negedge clk);
        start_s[1] = 1'b1;
        @(posedge clk);
        done_n = 0; x_err = 0;
        for (int n = 0; n < 57; n++) begin
            @(negedge clk);
            if ((n % 19) < 16) begin
                if (x_w[1] != 4'(n % 19)) x_err++;
            end else begin
                if (x_w[1] != 4'd0) x_err++;
            end
            if (done_w[1]) begin
                check_eq("held_done_cycle", 32'(n), 32'(17 + 19 * done_n));
                done_n++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("held_tt", 32'(tt_w[1]), 32'(e.tt));
                end else begin
                    check_eq("held_extra_done", 32'd1, 32'd0);
                end
            end
            if (n == 56) start_s[1] = 1'b0;
        end
        check_eq("held_done_count", 32'(done_n), 32'd3);
        check_eq("held_x_seq_errs", 32'(x_err), 32'd0);
        done_n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_w[1] || busy_w[1]) done_n++;
        end
        check_eq("held_no_extra_sweep", 32'(done_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/npn_tt_capture.md
NPN_TT_CAPTURE -- requirements
Module: npn_tt_capture

Interface
REQ-001 SHALL have parameter LAT, default 1, meaning the cycles from driving x to a valid y0 (legal 0..3).
REQ-002 SHALL have parameter EXP_TT, default 16'hE766, meaning the expected truth table; bit i is the output for minterm i = {x3,x2,x1,x0}.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests one sweep; sampled only in IDLE.
REQ-006 SHALL have ports x0, x1, x2, x3, each output, 1 bit: minterm bits driven to the downstream 4-input function.
REQ-007 SHALL have port y0, input, 1 bit: function output returned by the downstream block.
REQ-008 SHALL have port busy, output, 1 bit: high from the first DRIVE cycle through the last DRAIN cycle.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-010 SHALL have port tt, output, 16 bits: the captured truth table.
REQ-011 SHALL have port ones, output, 5 bits: the popcount of tt (0..16).
REQ-012 SHALL have port match, output, 1 bit: high when tt equals EXP_TT.

Function
REQ-013 SHALL implement the states IDLE, DRIVE, DRAIN and DONE.
REQ-014 SHALL go from IDLE to DRIVE on the edge where start=1; in IDLE, start=0 keeps IDLE.
REQ-015 SHALL drive {x3,x2,x1,x0}=k in the k-th DRIVE cycle, k=0..15 ascending, with a 4-bit index that must not wrap within a sweep.
REQ-016 SHALL go from DRIVE to DRAIN after k=15 when LAT>0, or directly to DONE when LAT=0.
REQ-017 SHALL stay in DRAIN exactly LAT cycles, then enter DONE.
REQ-018 SHALL hold x at 0 in IDLE, DRAIN and DONE.
REQ-019 SHALL write y0 into tt bit k in the cycle that is exactly LAT cycles after minterm k was driven; LAT=0 samples in the same cycle.
REQ-020 SHALL track capture with a valid/index delay line of depth LAT and no other timing assumption.
REQ-021 SHALL clear tt, ones and match on the cycle it leaves IDLE.
REQ-022 SHALL update ones incrementally with each captured 1.
REQ-023 SHALL update match from the final tt, with its final value visible in the DONE cycle.
REQ-024 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-025 SHALL hold tt, ones and match stable in IDLE until the next sweep starts.
REQ-026 SHALL ignore start while busy or done is high; it must neither restart nor queue a sweep.
REQ-027 SHALL accept start=1 in the cycle after DONE and begin a new sweep, i.e. back-to-back sweeps.
REQ-028 SHALL complete a sweep from start to the done pulse in 16+LAT+1 cycles after the start edge.

Reset
REQ-029 SHALL on rst=1, asynchronously and at any point including mid-sweep, force state IDLE, x=0, busy=0, done=0, tt=0, ones=0, match=0, and clear the delay line.
REQ-030 SHALL after rst deasserts, produce no done pulse until a new start is accepted.

Structure
REQ-031 SHALL place the following in the shared package npn_pkg: the state enum, constant TT_W=16, constant N_MINTERM=16 and the default EXP_TT.
REQ-032 SHALL implement the delay line as sub-module npn_lat_pipe, parameterised by LAT.
REQ-033 SHALL have an implementation size of about 120-400 RTL lines.

Verification
REQ-034 SHALL cover: LAT=1 with a combinational model of the downstream function registered one cycle, and one start -> x sequence 0..15, tt=16'hE766, ones=10, match=1, done exactly 18 cycles after the start edge.
REQ-035 SHALL cover: LAT=0 with y0 tied to x0^x1 -> tt=16'h6666, ones=8, match=0, done 17 cycles after the start edge.
REQ-036 SHALL cover: LAT=3 with y0 tied to 1 delayed 3 cycles -> tt=16'hFFFF, ones=16, busy high for 19 cycles.
REQ-037 SHALL cover: start held high continuously -> sweeps run back-to-back, one done per sweep, and start mid-sweep is never re-triggered.
REQ-038 SHALL cover: rst pulsed at DRIVE k=7 -> all outputs 0 immediately, IDLE entered, no done; a later start gives a correct full sweep.
REQ-039 SHALL cover: y0 stuck at 0 -> tt=0, ones=0, match=0, and results held in IDLE until the next start.
